// File: rtl/bitstream_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bitstream_refill_ctrl_if
//  Brief    : External memory read request/acknowledge bus for the refill ctrl
//  Revision : 1.0
// ============================================================================
interface bitstream_refill_ctrl_if #(
    parameter int ADDR_W = 20
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bitstream_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bitstream_refill_ctrl
//  Brief    : Refills the 4 x 32-bit circular bitstream window as the parser
//             bit pointer crosses slot boundaries; flags when enough bits remain.
//  Revision : 1.0
// ============================================================================
module bitstream_refill_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int MIN_BITS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [6:0]               pc,
    bitstream_refill_ctrl_if.master  mem,
    output logic                     buf_we,
    output logic [1:0]               buf_waddr,
    output logic [31:0]              buf_wdata,
    output logic                     bits_ready,
    output logic [2:0]               valid_words,
    output logic                     busy
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_fetch    = 2'd1;
    localparam logic [1:0] c_full     = 2'd2;
    localparam logic [7:0] c_min_bits = 8'(MIN_BITS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_wr_ptr;
    logic [2:0]        r_valid_words;
    logic [2:0]        w_valid_words_nxt;
    logic              r_bits_ready;
    logic              w_bits_ready_nxt;
    logic [1:0]        r_pc_slot_d;
    logic              w_consume;
    logic              w_ack;
    logic [7:0]        w_avail;

    // Reset and restart both take priority over an acknowledge in the same cycle.
    assign w_ack     = !reset && !start && r_mem_req && mem.mem_ack && (r_state == c_fetch);
    assign w_consume = (r_state != c_idle) && (pc[6:5] != r_pc_slot_d);

    always_comb begin
        w_state_nxt       = r_state;
        w_valid_words_nxt = r_valid_words;
        w_mem_req_nxt     = 1'b0;
        w_avail           = 8'd0;
        w_bits_ready_nxt  = 1'b0;

        if (w_ack && !w_consume) begin
            w_valid_words_nxt = r_valid_words + 3'd1;
        end else if (!w_ack && w_consume && (r_valid_words != 3'd0)) begin
            w_valid_words_nxt = r_valid_words - 3'd1;
        end

        case (r_state)
            c_idle:  w_state_nxt = c_idle;
            c_fetch: if (w_valid_words_nxt == 3'd4) w_state_nxt = c_full;
            c_full:  if (w_consume) w_state_nxt = c_fetch;
            default: w_state_nxt = c_idle;
        endcase

        if (start) begin
            w_state_nxt       = c_fetch;
            w_valid_words_nxt = 3'd0;
        end

        // Dropping the request for one cycle after each ack paces fetches at 1 word / 2 cycles.
        w_mem_req_nxt = !start && !w_ack && (w_state_nxt == c_fetch) && (w_valid_words_nxt < 3'd4);

        if (r_valid_words != 3'd0) begin
            w_avail = {r_valid_words, 5'b00000} - {3'b000, pc[4:0]};
        end
        w_bits_ready_nxt = (w_avail >= c_min_bits);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_wr_ptr      <= 2'd0;
            r_valid_words <= 3'd0;
            r_bits_ready  <= 1'b0;
            r_pc_slot_d   <= 2'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_valid_words <= w_valid_words_nxt;
            r_bits_ready  <= w_bits_ready_nxt;
            // A new stream begins at pc 0, so the slot tracker restarts there too.
            r_pc_slot_d   <= start ? 2'd0 : pc[6:5];
            if (start) begin
                r_mem_addr <= start_addr;
                r_wr_ptr   <= 2'd0;
            end else if (w_ack) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(1);
                r_wr_ptr   <= r_wr_ptr + 2'd1;
            end
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign buf_we       = w_ack;
    assign buf_waddr    = r_wr_ptr;
    assign buf_wdata    = mem.mem_rdata;
    assign bits_ready   = r_bits_ready;
    assign valid_words  = r_valid_words;
    assign busy         = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_bitstream_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitstream_refill_ctrl
//  Brief    : Scoreboard bench for bitstream_refill_ctrl window refills
//  Revision : 1.0
// ============================================================================
module tb_bitstream_refill_ctrl;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [6:0]        pc;
    logic              buf_we;
    logic [1:0]        buf_waddr;
    logic [31:0]       buf_wdata;
    logic              bits_ready;
    logic [2:0]        valid_words;
    logic              busy;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [33:0]       sb_q[$];
    logic [33:0]       sb_e;
    logic [1:0]        m_slot;
    logic [ADDR_W-1:0] m_addr;

    bitstream_refill_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();

    bitstream_refill_ctrl #(.ADDR_W(ADDR_W), .MIN_BITS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .pc          (pc),
        .mem         (mem_if),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .bits_ready  (bits_ready),
        .valid_words (valid_words),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // Every window write must match the oldest expected {slot, data}.
    always @(negedge clk) begin
        #2;
        if (buf_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_we", 32'(buf_we), 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("buf_waddr", 32'(buf_waddr), 32'(sb_e[33:32]));
                check_val("buf_wdata", buf_wdata, sb_e[31:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_if.mem_req === 1'b1) return;
        end
        check_val(tag, 32'(mem_if.mem_req), 32'd1);
    endtask

    task automatic do_ack();
        logic [31:0] d;
        d = 32'hC0DE_0000 ^ 32'(m_addr);
        check_val("req_addr", 32'(mem_if.mem_addr), 32'(m_addr));
        sb_q.push_back({m_slot, d});
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = d;
        @(posedge clk);
        #1;
        mem_if.mem_ack = 1'b0;
        m_slot++;
        m_addr++;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start      = 1'b1;
        start_addr = a;
        m_addr     = a;
        m_slot     = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0; pc = 7'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;
        m_slot = 2'd0; m_addr = '0;
        tick(3);
        check_val("rst_req",   32'(mem_if.mem_req),  32'd0);
        check_val("rst_addr",  32'(mem_if.mem_addr), 32'd0);
        check_val("rst_vw",    32'(valid_words),     32'd0);
        check_val("rst_ready", 32'(bits_ready),      32'd0);
        check_val("rst_busy",  32'(busy),            32'd0);
        check_val("rst_we",    32'(buf_we),          32'd0);
        reset = 1'b0;
        tick(1);

        // Fill the whole window from 0x100
        do_start(20'h00100);
        for (int i = 0; i < 4; i++) begin
            wait_req("t1_req_timeout");
            do_ack();
        end
        tick(1);
        check_val("t1_vw",   32'(valid_words),    32'd4);
        check_val("t1_req",  32'(mem_if.mem_req), 32'd0);
        check_val("t1_busy", 32'(busy),           32'd1);
        tick(3);
        check_val("t1_full_req", 32'(mem_if.mem_req), 32'd0);
        check_val("t1_ready",    32'(bits_ready),     32'd1);

        // Boundary crossing 31 -> 33 frees slot 0
        pc = 7'd31;
        tick(1);
        pc = 7'd33;
        tick(1);
        check_val("t2_vw",   32'(valid_words),     32'd3);
        check_val("t2_req",  32'(mem_if.mem_req),  32'd1);
        check_val("t2_addr", 32'(mem_if.mem_addr), 32'h104);
        do_ack();
        tick(1);
        check_val("t2_vw_refill", 32'(valid_words), 32'd4);

        // Ack coincident with a consume
        pc = 7'd65;
        tick(1);
        check_val("t3_vw_pre", 32'(valid_words), 32'd3);
        pc = 7'd97;
        do_ack();
        tick(1);
        check_val("t3_vw",   32'(valid_words),     32'd3);
        check_val("t3_addr", 32'(mem_if.mem_addr), 32'h106);
        check_val("t3_gap",  32'(mem_if.mem_req),  32'd0);

        // Withheld ack while the parser drains the window
        wait_req("t4_req_timeout");
        for (int i = 0; i < 20; i++) begin
            check_val("t4_req_hold",  32'(mem_if.mem_req),  32'd1);
            check_val("t4_addr_hold", 32'(mem_if.mem_addr), 32'h106);
            if (i == 3) pc = 7'd8;
            if (i == 6) pc = 7'd40;
            if (i == 7) begin
                check_val("t4_vw",         32'(valid_words), 32'd1);
                check_val("t4_ready_late", 32'(bits_ready),  32'd1);
            end
            if (i == 8) check_val("t4_ready_low", 32'(bits_ready), 32'd0);
            tick(1);
        end
        do_ack();
        tick(1);
        check_val("t4_vw_after", 32'(valid_words), 32'd2);

        // Restart with a pending request and a coincident ack
        wait_req("t5_req_timeout");
        start            = 1'b1;
        start_addr       = 20'h02000;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("t5_we_drop", 32'(buf_we), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        mem_if.mem_ack = 1'b0;
        m_addr = 20'h02000;
        m_slot = 2'd0;
        @(negedge clk);
        pc = 7'd0;
        check_val("t5_vw",   32'(valid_words),     32'd0);
        check_val("t5_req",  32'(mem_if.mem_req),  32'd0);
        check_val("t5_addr", 32'(mem_if.mem_addr), 32'h2000);
        check_val("t5_busy", 32'(busy),            32'd1);
        wait_req("t5_req2_timeout");
        do_ack();
        tick(1);
        check_val("t5_vw_one", 32'(valid_words), 32'd1);
        tick(1);
        check_val("t5_ready_eq_min", 32'(bits_ready), 32'd1);

        // Address wrap, then reset mid-stream with a late ack
        do_start(20'hFFFFE);
        for (int i = 0; i < 3; i++) begin
            wait_req("t6_req_timeout");
            do_ack();
        end
        wait_req("t6_req4_timeout");
        check_val("t6_wrap_addr", 32'(mem_if.mem_addr), 32'h1);
        reset            = 1'b1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'h1234_5678;
        #1;
        check_val("t6_we_rst", 32'(buf_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_val("t6_req",   32'(mem_if.mem_req),  32'd0);
        check_val("t6_addr",  32'(mem_if.mem_addr), 32'd0);
        check_val("t6_vw",    32'(valid_words),     32'd0);
        check_val("t6_ready", 32'(bits_ready),      32'd0);
        check_val("t6_busy",  32'(busy),            32'd0);
        check_val("t6_waddr", 32'(buf_waddr),       32'd0);
        tick(1);
        check_val("t6_idle_we", 32'(buf_we),      32'd0);
        check_val("t6_idle_vw", 32'(valid_words), 32'd0);
        mem_if.mem_ack = 1'b0;
        tick(2);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
